// File: rtl/syscall_console_if.sv
// -----------------------------------------------------------------------------
// syscall_console_if
//
// Groups the CPU-side syscall handshake of syscall_console:
//   syscall  CPU -> console  high for the whole syscall instruction cycle
//   v0       CPU -> console  32-bit syscall code
//   a0       CPU -> console  32-bit syscall argument
//   go       console -> CPU  one-cycle resume pulse (registered by the console)
//
// Modports:
//   master   the CPU side (drives syscall/v0/a0, receives go)
//   slave    the console side (receives syscall/v0/a0, drives go)
// -----------------------------------------------------------------------------
interface syscall_console_if;
    logic        syscall;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        go;

    modport master (output syscall, output v0, output a0, input go);
    modport slave  (input syscall, input v0, input a0, output go);
endinterface

// File: rtl/syscall_console.sv
// -----------------------------------------------------------------------------
// syscall_console
//
// Board-side responder for the single-cycle CPU's syscall stall/resume
// handshake. Decodes the syscall code/argument presented during a syscall
// cycle, latches print values onto an 8-digit multiplexed seven-segment
// display, and releases a stalled CPU with a one-cycle go pulse generated
// from a synchronized, debounced pushbutton.
//
// Syscall codes:
//   34      print: latch a0 into disp_val, no stall
//   10      exit: enter HALT, halted stays high until reset
//   other   stall: wait for a button press, then pulse go
//
// Ports:
//   clk       system clock, all state on the rising edge
//   clr       asynchronous active-low reset
//   cpu       syscall_console_if.slave (syscall, v0, a0 in; go out)
//   btn_go    raw asynchronous pushbutton, active-high
//   halted    program exited, sticky until reset
//   disp_val  value currently shown on the display
//   an        digit enables, active-low, one digit at a time
//   seg       segments, active-low, seg[7] = dp (always off), seg[6:0] = g..a
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept a new level
//   SCAN_DIV         clock cycles each digit is held
//   AUTO_CYCLES      WAIT timeout, used only with SYSCALL_AUTO_GO_EN
//
// Build option:
//   SYSCALL_AUTO_GO_EN  when defined, WAIT also exits to GO after AUTO_CYCLES
//                       cycles without a press. Undefined: only a press
//                       leaves WAIT.
// -----------------------------------------------------------------------------
module syscall_console #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_DIV        = 100000,
    parameter int AUTO_CYCLES     = 50000000
) (
    input  logic                clk,
    input  logic                clr,
    syscall_console_if.slave    cpu,
    input  logic                btn_go,
    output logic                halted,
    output logic [31:0]         disp_val,
    output logic [7:0]          an,
    output logic [7:0]          seg
);

    localparam logic [31:0] CODE_EXIT  = 32'd10;
    localparam logic [31:0] CODE_PRINT = 32'd34;
    localparam int          DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int          SCAN_W     = $clog2(SCAN_DIV + 1);

    // Reject parameter values that would make the counters meaningless.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("syscall_console: DEBOUNCE_CYCLES must be at least 1");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan
        $error("syscall_console: SCAN_DIV must be at least 1");
    end
    if (AUTO_CYCLES < 1) begin : g_bad_auto
        $error("syscall_console: AUTO_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_HALT
    } state_t;

    // -------------------------------------------------------------------------
    // Button path: 2-FF synchronizer, debouncer, rising-edge detect
    // -------------------------------------------------------------------------
    logic            sync_meta;
    logic            sync_out;
    logic            btn_db;
    logic            btn_db_d;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others; blocking here would chain the two
    // synchronizer stages into one.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= btn_go;
            sync_out  <= sync_meta;
        end
    end

    // The counter tracks consecutive samples that disagree with btn_db; the
    // level flips on the DEBOUNCE_CYCLES-th such sample.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_d <= 1'b0;
        end else begin
            btn_db_d <= btn_db;
            if (sync_out == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= sync_out;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = btn_db & ~btn_db_d;

    // -------------------------------------------------------------------------
    // Syscall FSM
    // -------------------------------------------------------------------------
    state_t state;
    state_t state_next;
    logic   load_disp;
    logic   auto_fire;

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a value unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        load_disp  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cpu.syscall) begin
                    if (cpu.v0 == CODE_PRINT) begin
                        load_disp = 1'b1;
                    end else if (cpu.v0 == CODE_EXIT) begin
                        state_next = S_HALT;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (press || auto_fire) begin
                    state_next = S_GO;
                end
            end
            S_GO:    state_next = S_IDLE;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

`ifdef SYSCALL_AUTO_GO_EN
    localparam int AUTO_W = $clog2(AUTO_CYCLES + 1);

    logic [AUTO_W-1:0] auto_cnt;

    // Counts cycles spent in WAIT; zero on the first WAIT cycle, cleared as
    // soon as WAIT is left (by press or by timeout).
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            auto_cnt <= '0;
        end else if (state == S_WAIT && state_next == S_WAIT) begin
            auto_cnt <= auto_cnt + 1'b1;
        end else begin
            auto_cnt <= '0;
        end
    end

    assign auto_fire = (state == S_WAIT) && (auto_cnt == AUTO_W'(AUTO_CYCLES - 1));
`else
    assign auto_fire = 1'b0;
`endif

    // go and halted are decoded from the next state so they are true flops
    // that are high exactly while the FSM sits in GO / HALT.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_IDLE;
            cpu.go   <= 1'b0;
            halted   <= 1'b0;
            disp_val <= '0;
        end else begin
            state  <= state_next;
            cpu.go <= (state_next == S_GO);
            halted <= (state_next == S_HALT);
            if (load_disp) begin
                disp_val <= cpu.a0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Display scan
    // -------------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        digit_idx;
    logic              scan_wrap;
    logic [2:0]        digit_next;
    logic [31:0]       disp_next;
    logic [3:0]        nibble;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        g = 7'h7F;
        case (nib)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign digit_next = scan_wrap ? digit_idx + 3'd1 : digit_idx;
    // an/seg are built from the post-edge digit and value, so a wrap that
    // coincides with a print shows the new value on the new digit at once.
    assign disp_next  = load_disp ? cpu.a0 : disp_val;
    assign nibble     = disp_next[{digit_next, 2'b00} +: 4];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
            an        <= 8'hFE;
            seg       <= 8'hC0;
        end else begin
            scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
            digit_idx <= digit_next;
            an        <= ~(8'b1 << digit_next);
            seg       <= {1'b1, hex_glyph(nibble)};
        end
    end

endmodule

// File: tb/tb_syscall_console.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_syscall_console
//
// Self-checking bench for syscall_console with DEBOUNCE_CYCLES=4, SCAN_DIV=2,
// AUTO_CYCLES=8. Directed scenario tasks check latencies against constants;
// a randomized phase compares every output each cycle against a behavioural
// model built from the block's rules (sample history queue, mode number,
// cycle count since reset for the scan position).
// -----------------------------------------------------------------------------
module tb_syscall_console;

    localparam int DB = 4;
    localparam int SD = 2;
    localparam int AC = 8;
`ifdef SYSCALL_AUTO_GO_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        btn_go = 1'b0;
    logic        halted;
    logic [31:0] disp_val;
    logic [7:0]  an;
    logic [7:0]  seg;

    int errors = 0;
    int checks = 0;

    syscall_console_if bus ();

    syscall_console #(
        .DEBOUNCE_CYCLES(DB),
        .SCAN_DIV(SD),
        .AUTO_CYCLES(AC)
    ) dut (
        .clk(clk),
        .clr(clr),
        .cpu(bus),
        .btn_go(btn_go),
        .halted(halted),
        .disp_val(disp_val),
        .an(an),
        .seg(seg)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    logic [6:0]  glyph_tab [16];
    int          m_mode;        // 0 idle, 1 waiting, 2 go, 3 halted
    logic        m_raw [$];     // raw button samples not yet through the synchronizer
    logic        m_db;
    int          m_run;
    logic        m_press;
    int          m_wait_age;
    int          m_n;           // rising edges since reset release
    logic [31:0] m_disp;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_mode     = 0;
            m_raw      = {1'b0, 1'b0};
            m_db       = 1'b0;
            m_run      = 0;
            m_press    = 1'b0;
            m_wait_age = 0;
            m_n        = 0;
            m_disp     = '0;
        end else begin
            int   nxt;
            logic s;
            nxt = m_mode;
            case (m_mode)
                0: if (bus.syscall === 1'b1) begin
                       if (bus.v0 == 32'd34)      m_disp = bus.a0;
                       else if (bus.v0 == 32'd10) nxt = 3;
                       else                       nxt = 1;
                   end
                1: if (m_press || (AUTO_EN && m_wait_age == AC - 1)) nxt = 2;
                2: nxt = 0;
                default: nxt = 3;
            endcase
            m_wait_age = (m_mode == 1 && nxt == 1) ? m_wait_age + 1 : 0;
            m_mode = nxt;
            // Synchronized sample seen now is the raw level from two edges ago.
            s = m_raw.pop_front();
            m_raw.push_back(btn_go);
            m_press = 1'b0;
            if (s != m_db) begin
                m_run++;
                if (m_run == DB) begin
                    m_db    = s;
                    m_run   = 0;
                    m_press = s;
                end
            end else begin
                m_run = 0;
            end
            m_n++;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        btn_go = 1'b0;
        bus.syscall = 1'b0;
        repeat (2) cyc();
        clr = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        logic [7:0] exp_an;
        clr = 1'b0;
        btn_go = 1'b0;
        bus.syscall = 1'b0;
        repeat (2) cyc();
        checks++; if (bus.go !== 1'b0) begin errors++; $display("FAIL reset_go: got %b want 0", bus.go); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (disp_val !== 32'h0) begin errors++; $display("FAIL reset_disp: got %h want 0", disp_val); end
        checks++; if (an !== 8'hFE) begin errors++; $display("FAIL reset_an: got %h want fe", an); end
        checks++; if (seg !== 8'hC0) begin errors++; $display("FAIL reset_seg: got %h want c0", seg); end
        clr = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) cyc();
            exp_an = ~(8'd1 << ((k / SD) % 8));
            checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an[%0d]: got %h want %h", k, an, exp_an); end
            checks++; if (seg !== 8'hC0) begin errors++; $display("FAIL scan_seg[%0d]: got %h want c0", k, seg); end
        end
    endtask

    task automatic test_print();
        bit seen0 = 1'b0;
        bit seen7 = 1'b0;
        int gos = 0;
        bus.syscall = 1'b1;
        bus.v0 = 32'd34;
        bus.a0 = 32'h1234ABCD;
        cyc();
        bus.syscall = 1'b0;
        bus.v0 = 32'd34;
        bus.a0 = 32'hFFFF_FFFF;
        checks++; if (disp_val !== 32'h1234ABCD) begin errors++; $display("FAIL print_disp: got %h want 1234abcd", disp_val); end
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (bus.go !== 1'b0) gos++;
            if (an === 8'hFE) begin
                seen0 = 1'b1;
                checks++; if (seg !== 8'hA1) begin errors++; $display("FAIL print_digit0: got %h want a1", seg); end
            end
            if (an === 8'h7F) begin
                seen7 = 1'b1;
                checks++; if (seg !== 8'hF9) begin errors++; $display("FAIL print_digit7: got %h want f9", seg); end
            end
        end
        checks++; if (!(seen0 && seen7)) begin errors++; $display("FAIL print_scan_seen: got %b%b want 11", seen0, seen7); end
        checks++; if (gos !== 0) begin errors++; $display("FAIL print_no_go: got %0d go cycles want 0", gos); end
        checks++; if (disp_val !== 32'h1234ABCD) begin errors++; $display("FAIL print_hold: got %h want 1234abcd", disp_val); end
    endtask

    task automatic test_wait_press();
        int gos = 0;
        int pulses = 0;
        int first = -1;
        bus.syscall = 1'b1;
        bus.v0 = 32'd5;
        cyc();
        bus.syscall = 1'b0;
        checks++; if (bus.go !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL wait_entry: got go=%b halted=%b want 0 0", bus.go, halted); end
        repeat (2) begin
            btn_go = 1'b1;
            repeat (3) begin cyc(); if (bus.go !== 1'b0) gos++; end
            btn_go = 1'b0;
            repeat (4) begin cyc(); if (bus.go !== 1'b0) gos++; end
        end
        checks++; if (gos !== 0) begin errors++; $display("FAIL bounce_no_go: got %0d go cycles want 0", gos); end
        btn_go = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (bus.go === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (k == 6) btn_go = 1'b0;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL press_pulses: got %0d want 1", pulses); end
        checks++; if (first !== 7) begin errors++; $display("FAIL press_latency: got %0d want 7", first); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int hold = 0;
        btn_go = 1'b0;
        bus.syscall = 1'b1;
        bus.v0 = 32'd5;
        cyc();
        bus.syscall = 1'b0;
        btn_go = 1'b1;
        // On each go, keep syscall high through the following IDLE cycle,
        // as the next syscall instruction would.
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (bus.go === 1'b1) begin pulses++; hold = 2; end
            bus.syscall = (hold > 0);
            if (hold > 0) hold--;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_held: got %0d go pulses want 1", pulses); end
        pulses = 0;
        btn_go = 1'b0;
        repeat (10) begin cyc(); if (bus.go === 1'b1) pulses++; end
        btn_go = 1'b1;
        repeat (12) begin cyc(); if (bus.go === 1'b1) pulses++; end
        btn_go = 1'b0;
        repeat (10) begin cyc(); if (bus.go === 1'b1) pulses++; end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_repress: got %0d go pulses want 1", pulses); end
    endtask

    task automatic test_halt();
        int gos = 0;
        int not_halted = 0;
        bus.syscall = 1'b1;
        bus.v0 = 32'd10;
        cyc();
        bus.syscall = 1'b0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", halted); end
        for (int k = 0; k < 30; k++) begin
            btn_go = (k >= 2 && k < 12);
            bus.syscall = (k == 20);
            bus.v0 = 32'd5;
            cyc();
            if (bus.go !== 1'b0) gos++;
            if (halted !== 1'b1) not_halted++;
        end
        bus.syscall = 1'b0;
        checks++; if (gos !== 0) begin errors++; $display("FAIL halt_no_go: got %0d go cycles want 0", gos); end
        checks++; if (not_halted !== 0) begin errors++; $display("FAIL halt_sticky: got %0d low cycles want 0", not_halted); end
        clr = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b want 0", halted); end
        checks++; if (disp_val !== 32'h0) begin errors++; $display("FAIL halt_clear_disp: got %h want 0", disp_val); end
        cyc();
        clr = 1'b1;
    endtask

    task automatic test_reset_mid_go();
        int found = 0;
        // Reset while waiting, then prove IDLE by a print being accepted.
        bus.syscall = 1'b1;
        bus.v0 = 32'd5;
        cyc();
        bus.syscall = 1'b0;
        repeat (3) cyc();
        do_reset();
        cyc();
        bus.syscall = 1'b1;
        bus.v0 = 32'd34;
        bus.a0 = 32'hCAFE_0042;
        cyc();
        bus.syscall = 1'b0;
        checks++; if (disp_val !== 32'hCAFE_0042) begin errors++; $display("FAIL rst_wait_idle: got %h want cafe0042", disp_val); end
        // Reset while go is high.
        bus.syscall = 1'b1;
        bus.v0 = 32'd7;
        cyc();
        bus.syscall = 1'b0;
        btn_go = 1'b1;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cyc();
            if (bus.go === 1'b1) found = 1;
        end
        checks++; if (found !== 1) begin errors++; $display("FAIL rst_go_reach: got no go within 20 cycles want go"); end
        clr = 1'b0;
        #1;
        checks++; if (bus.go !== 1'b0) begin errors++; $display("FAIL rst_go_drop: got %b want 0", bus.go); end
        cyc();
        clr = 1'b1;
        btn_go = 1'b0;
        repeat (10) cyc();
        bus.syscall = 1'b1;
        bus.v0 = 32'd34;
        bus.a0 = 32'h0BAD_F00D;
        cyc();
        bus.syscall = 1'b0;
        checks++; if (disp_val !== 32'h0BAD_F00D) begin errors++; $display("FAIL rst_go_idle: got %h want 0badf00d", disp_val); end
    endtask

    task automatic test_auto();
        int first = -1;
        int pulses = 0;
        btn_go = 1'b0;
        bus.syscall = 1'b1;
        bus.v0 = 32'd5;
        for (int k = 1; k <= 100; k++) begin
            cyc();
            bus.syscall = 1'b0;
            if (bus.go === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        if (AUTO_EN) begin
            checks++; if (first !== 1 + AC) begin errors++; $display("FAIL auto_latency: got %0d want %0d", first, 1 + AC); end
            checks++; if (pulses !== 1) begin errors++; $display("FAIL auto_pulses: got %0d want 1", pulses); end
        end else begin
            checks++; if (pulses !== 0) begin errors++; $display("FAIL no_auto: got %0d go pulses want 0", pulses); end
        end
    endtask

    task automatic test_random();
        int          hold_left = 0;
        int          r;
        logic [7:0]  exp_an;
        logic [7:0]  exp_seg;
        logic [31:0] nib_src;
        int          idx;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            cyc();
            idx     = (m_n / SD) % 8;
            exp_an  = ~(8'd1 << idx);
            nib_src = m_disp >> (4 * idx);
            exp_seg = {1'b1, glyph_tab[nib_src[3:0]]};
            checks++; if (bus.go !== (m_mode == 2)) begin errors++; $display("FAIL rnd_go[%0d]: got %b want %b", k, bus.go, (m_mode == 2)); end
            checks++; if (halted !== (m_mode == 3)) begin errors++; $display("FAIL rnd_halted[%0d]: got %b want %b", k, halted, (m_mode == 3)); end
            checks++; if (disp_val !== m_disp) begin errors++; $display("FAIL rnd_disp[%0d]: got %h want %h", k, disp_val, m_disp); end
            checks++; if (an !== exp_an) begin errors++; $display("FAIL rnd_an[%0d]: got %h want %h", k, an, exp_an); end
            checks++; if (seg !== exp_seg) begin errors++; $display("FAIL rnd_seg[%0d]: got %h want %h", k, seg, exp_seg); end
            if (hold_left == 0) begin
                btn_go = ~btn_go;
                hold_left = $urandom_range(1, 9);
            end
            hold_left--;
            bus.a0 = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                bus.syscall = 1'b1;
                r = $urandom_range(0, 3);
                case (r)
                    0: bus.v0 = 32'd34;
                    1: bus.v0 = 32'd5;
                    2: begin
                           bus.v0 = $urandom;
                           if (bus.v0 == 32'd10 || bus.v0 == 32'd34) bus.v0 = 32'd99;
                       end
                    default: bus.v0 = 32'd34 | (32'd1 << $urandom_range(6, 31));
                endcase
            end else begin
                bus.syscall = 1'b0;
                bus.v0 = $urandom;
            end
        end
        bus.syscall = 1'b0;
    endtask

    initial begin
        glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
        glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
        glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
        glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
        glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
        glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b0000011;
        glyph_tab[12] = 7'b1000110; glyph_tab[13] = 7'b0100001;
        glyph_tab[14] = 7'b0000110; glyph_tab[15] = 7'b0001110;
        bus.syscall = 1'b0;
        bus.v0 = '0;
        bus.a0 = '0;

        test_reset();
        test_print();
        test_wait_press();
        test_back_to_back();
        test_halt();
        test_reset_mid_go();
        test_auto();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
